instr_fetch_queue: RTL



---
 rtl/mips_if_pkg.sv | 19 +
 rtl/sync_fifo.sv | 75 +++++++
 rtl/instr_fetch_queue.sv | 115 +++++++++++
 3 files changed

// File: rtl/mips_if_pkg.sv
// Shared fetch-stage types: widths, PC step and the {pc, instr} entry layout
// handed from instruction fetch to decode.
package mips_if_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; the head word reads as zero while empty.
// Push and pop together on a full FIFO are accepted and leave the count unchanged.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Handshake qualification and head presentation.
  always_comb begin
    empty     = (count_r == {(AW + 1){1'b0}});
    full      = (count_r == FULL_CNT);
    count     = count_r;
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    if (empty) begin
      dout = {WIDTH{1'b0}};
    end else begin
      dout = mem_r[rd_ptr_r];
    end
  end

  // Storage array: contents are never observed while empty, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push_s && !clear) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1'b1);
        2'b01:   count_r <= count_r - (AW + 1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: credit-limited word reads to instruction memory, PC tagging of
// returned words, and redirect flush that drops reads still in flight.
module instr_fetch_queue
  import mips_if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               redirect,
  output logic               pc_consume,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus4,
  output logic               proto_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(DEPTH);

  logic [CW-1:0]     outstanding_r;
  logic [CW-1:0]     drop_cnt_r;
  logic              proto_err_r;
  logic [CW-1:0]     tag_count_s;
  logic [CW-1:0]     out_count_s;
  logic              tag_full_s, tag_empty_s, out_full_s, out_empty_s;
  logic [ADDR_W-1:0] tag_pc_s;
  fetch_entry_t      out_din_s, out_head_s;
  logic [CW:0]       credit_sum_s;
  logic              issue_s, rsp_live_s, stray_s, deliver_s, pop_s;
  logic              unused_s;

  // Credit check, handshakes and decode-side view of the queue head.
  always_comb begin
    credit_sum_s   = {1'b0, outstanding_r} + {1'b0, out_count_s};
    rsp_live_s     = imem_rsp_valid && (outstanding_r != {CW{1'b0}});
    stray_s        = imem_rsp_valid && (outstanding_r == {CW{1'b0}});
    imem_req_valid = !rst && !redirect && (credit_sum_s < CREDIT_LIMIT);
    issue_s        = imem_req_valid && imem_req_ready;
    pc_consume     = issue_s;
    imem_req_addr  = word_align(pc_in);
    deliver_s      = rsp_live_s && !redirect && (drop_cnt_r == {CW{1'b0}}) && !tag_empty_s;
    out_din_s.pc    = tag_pc_s;
    out_din_s.instr = imem_rsp_data;
    if_valid       = !out_empty_s;
    pop_s          = if_valid && if_ready;
    if_instr       = out_head_s.instr;
    if_pc          = out_head_s.pc;
    if (if_valid) begin
      if_pc_plus4 = out_head_s.pc + PC_STEP;
    end else begin
      if_pc_plus4 = {ADDR_W{1'b0}};
    end
    proto_err      = proto_err_r;
    unused_s       = ^{tag_count_s, tag_full_s, out_full_s};
  end

  // In-flight read count, stale-response drop count and sticky protocol error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_r <= {CW{1'b0}};
      drop_cnt_r    <= {CW{1'b0}};
      proto_err_r   <= 1'b0;
    end else begin
      proto_err_r <= proto_err_r | stray_s;
      if (redirect) begin
        // Everything still in flight after this edge belongs to the old path.
        outstanding_r <= outstanding_r - CW'(rsp_live_s);
        drop_cnt_r    <= outstanding_r - CW'(rsp_live_s);
      end else begin
        outstanding_r <= outstanding_r + CW'(issue_s) - CW'(rsp_live_s);
        if (rsp_live_s && (drop_cnt_r != {CW{1'b0}})) begin
          drop_cnt_r <= drop_cnt_r - CW'(1'b1);
        end else begin
          drop_cnt_r <= drop_cnt_r;
        end
      end
    end
  end

  sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect),
    .push  (issue_s),
    .pop   (deliver_s),
    .din   (pc_in),
    .dout  (tag_pc_s),
    .full  (tag_full_s),
    .empty (tag_empty_s),
    .count (tag_count_s)
  );

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_out_q (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect),
    .push  (deliver_s),
    .pop   (pop_s),
    .din   (out_din_s),
    .dout  (out_head_s),
    .full  (out_full_s),
    .empty (out_empty_s),
    .count (out_count_s)
  );

endmodule
